// File: rtl/dvs_line_xfer_sched_if.sv
// dvs_line_xfer_sched_if
// Command/completion bus between the line-transfer scheduler and the CDMA
// engine.
//   xfer_ready  CDMA idle and able to accept a command
//   xfer_done   1-cycle pulse, current transfer finished
//   xfer_err    qualified by xfer_done, the finished transfer failed
//   xfer_start  1-cycle command strobe
//   xfer_src    source byte address, held from xfer_start until xfer_done
//   xfer_dst    destination byte address, same hold rule as xfer_src
//   xfer_len    byte count of the transfer
// master = scheduler side, slave = CDMA side.
interface dvs_line_xfer_sched_if;
  logic        xfer_ready;
  logic        xfer_done;
  logic        xfer_err;
  logic        xfer_start;
  logic [31:0] xfer_src;
  logic [31:0] xfer_dst;
  logic [22:0] xfer_len;

  modport master (
    input  xfer_ready, xfer_done, xfer_err,
    output xfer_start, xfer_src, xfer_dst, xfer_len
  );

  modport slave (
    output xfer_ready, xfer_done, xfer_err,
    input  xfer_start, xfer_src, xfer_dst, xfer_len
  );
endinterface

// File: rtl/dvs_line_xfer_sched.sv
// dvs_line_xfer_sched
// Turns the DVS core's read/write line requests into CDMA line transfers.
// Reads fetch the next previous-frame line from DDR into a BRAM ping-pong
// buffer. Writes store the freshly computed line from BRAM back to DDR.
// A single CDMA engine is shared, and writes win arbitration so a line is
// written back before its slot is overwritten.
// Ports:
//   pclk, reset      clock (rising edge), asynchronous active-high reset
//   new_frame        start-of-frame pulse, rewinds indices/banks/offsets
//   read_new_line    request to fetch the next line
//   write_new_line   request to store the next line
//   xfer             CDMA command bus (master side)
//   rd_bank/wr_bank  BRAM banks the core may currently use
//   rd_line/wr_line  index of the next line to fetch / store
//   busy             a command is being issued or is in flight
//   overrun          sticky, request arrived while the same type was pending
//   error            sticky, CDMA reported a failed transfer
module dvs_line_xfer_sched #(
  parameter int unsigned LINE_BYTES   = 640,
  parameter int unsigned NUM_LINES    = 480,
  parameter logic [31:0] FRAME_BASE   = 32'h1000_0000,
  parameter logic [31:0] BRAM_RD_BASE = 32'hC000_0000,
  parameter logic [31:0] BRAM_WR_BASE = 32'hC000_1000
) (
  input  logic                         pclk,
  input  logic                         reset,
  input  logic                         new_frame,
  input  logic                         read_new_line,
  input  logic                         write_new_line,
  dvs_line_xfer_sched_if.master        xfer,
  output logic                         rd_bank,
  output logic                         wr_bank,
  output logic [9:0]                   rd_line,
  output logic [9:0]                   wr_line,
  output logic                         busy,
  output logic                         overrun,
  output logic                         error
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERROR} state_t;

  localparam logic [31:0] LINE_STEP = 32'(LINE_BYTES);
  localparam logic [9:0]  LAST_LINE = 10'(NUM_LINES - 1);

  state_t      state, state_nx;
  logic        rd_pend, wr_pend;
  logic        frame_defer;
  logic        cur_wr;
  logic [31:0] rd_off, wr_off;
  logic [31:0] src_r, dst_r;

  logic issue_go, issue_wr, issue_rd;
  logic xfer_fin, apply_frame, done_ok, done_err;

  // Event decode and next-state logic.
  always_comb begin
    state_nx    = state;
    // A new_frame in IDLE wins over issuing: the pending flags it would
    // serve are being discarded in the same cycle.
    issue_go    = (state == IDLE) && !new_frame && (rd_pend || wr_pend) &&
                  xfer.xfer_ready;
    issue_wr    = issue_go && wr_pend;
    issue_rd    = issue_go && !wr_pend;
    xfer_fin    = (state == WAIT) && xfer.xfer_done;
    // Frame restart is applied immediately when no transfer is in flight,
    // otherwise it waits for the completion of the current transfer.
    apply_frame = (new_frame && ((state == IDLE) || (state == ERROR))) ||
                  (xfer_fin && (frame_defer || new_frame));
    done_ok     = xfer_fin && !apply_frame && !xfer.xfer_err;
    done_err    = xfer_fin && !apply_frame && xfer.xfer_err;

    unique case (state)
      IDLE:  if (issue_go) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (apply_frame)   state_nx = IDLE;
        else if (done_err) state_nx = ERROR;
        else if (done_ok)  state_nx = IDLE;
      end
      ERROR: if (apply_frame) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Request flags, sticky status, line bookkeeping and command addresses.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      rd_pend     <= 1'b0;
      wr_pend     <= 1'b0;
      overrun     <= 1'b0;
      error       <= 1'b0;
      frame_defer <= 1'b0;
      cur_wr      <= 1'b0;
      rd_line     <= '0;
      wr_line     <= '0;
      rd_off      <= '0;
      wr_off      <= '0;
      rd_bank     <= 1'b0;
      wr_bank     <= 1'b0;
      src_r       <= '0;
      dst_r       <= '0;
    end else begin
      if (apply_frame) begin
        // Requests in the restart cycle belong to the new frame.
        rd_pend     <= read_new_line;
        wr_pend     <= write_new_line;
        overrun     <= 1'b0;
        error       <= 1'b0;
        frame_defer <= 1'b0;
        rd_line     <= '0;
        wr_line     <= '0;
        rd_off      <= '0;
        wr_off      <= '0;
        rd_bank     <= 1'b0;
        wr_bank     <= 1'b0;
      end else begin
        // A pulse coinciding with the issue of its own type re-arms the
        // flag as a fresh request rather than counting as overrun.
        rd_pend <= issue_rd ? read_new_line  : (rd_pend | read_new_line);
        wr_pend <= issue_wr ? write_new_line : (wr_pend | write_new_line);
        if ((read_new_line && rd_pend && !issue_rd) ||
            (write_new_line && wr_pend && !issue_wr))
          overrun <= 1'b1;
        if (done_err)
          error <= 1'b1;
        if (new_frame && ((state == ISSUE) || (state == WAIT)))
          frame_defer <= 1'b1;
        if (done_ok) begin
          if (cur_wr) begin
            wr_bank <= ~wr_bank;
            if (wr_line == LAST_LINE) begin
              wr_line <= '0;
              wr_off  <= '0;
            end else begin
              wr_line <= wr_line + 10'd1;
              wr_off  <= wr_off + LINE_STEP;
            end
          end else begin
            rd_bank <= ~rd_bank;
            if (rd_line == LAST_LINE) begin
              rd_line <= '0;
              rd_off  <= '0;
            end else begin
              rd_line <= rd_line + 10'd1;
              rd_off  <= rd_off + LINE_STEP;
            end
          end
        end
      end

      // Addresses are captured on entry to ISSUE and held until completion.
      if (issue_go) begin
        cur_wr <= wr_pend;
        if (wr_pend) begin
          src_r <= wr_bank ? (BRAM_WR_BASE + LINE_STEP) : BRAM_WR_BASE;
          dst_r <= FRAME_BASE + wr_off;
        end else begin
          src_r <= FRAME_BASE + rd_off;
          dst_r <= rd_bank ? (BRAM_RD_BASE + LINE_STEP) : BRAM_RD_BASE;
        end
      end
    end
  end

  assign xfer.xfer_start = (state == ISSUE);
  assign xfer.xfer_src   = src_r;
  assign xfer.xfer_dst   = dst_r;
  assign xfer.xfer_len   = 23'(LINE_BYTES);
  assign busy            = (state == ISSUE) || (state == WAIT);

endmodule

// File: tb/tb_dvs_line_xfer_sched.sv
// tb_dvs_line_xfer_sched
// Drives dvs_line_xfer_sched with directed and randomized request/CDMA
// traffic and compares every output each cycle against a reference model
// that tracks completed-line counts and derives addresses arithmetically.
module tb_dvs_line_xfer_sched;
  localparam int          LB = 640;
  localparam int          NL = 480;
  localparam logic [31:0] FB = 32'h1000_0000;
  localparam logic [31:0] RB = 32'hC000_0000;
  localparam logic [31:0] WB = 32'hC000_1000;

  logic       pclk = 1'b0;
  logic       reset;
  logic       new_frame, read_new_line, write_new_line;
  logic       rd_bank, wr_bank;
  logic [9:0] rd_line, wr_line;
  logic       busy, overrun, error;

  dvs_line_xfer_sched_if xif();

  dvs_line_xfer_sched dut (
    .pclk           (pclk),
    .reset          (reset),
    .new_frame      (new_frame),
    .read_new_line  (read_new_line),
    .write_new_line (write_new_line),
    .xfer           (xif),
    .rd_bank        (rd_bank),
    .wr_bank        (wr_bank),
    .rd_line        (rd_line),
    .wr_line        (wr_line),
    .busy           (busy),
    .overrun        (overrun),
    .error          (error)
  );

  always #5 pclk = ~pclk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 command strobe, 2 in flight, 3 halted.
  int          m_ph;
  bit          m_rd_pend, m_wr_pend, m_over, m_err, m_defer, m_cur_wr;
  int          m_rd_cnt, m_wr_cnt;
  logic [31:0] m_src, m_dst;
  int          cd_lat, lat_lo, lat_hi, err_pct;

  task automatic model_reset();
    m_ph = 0; m_rd_pend = 0; m_wr_pend = 0; m_over = 0; m_err = 0;
    m_defer = 0; m_cur_wr = 0; m_rd_cnt = 0; m_wr_cnt = 0;
    m_src = '0; m_dst = '0; cd_lat = 0;
  endtask

  task automatic model_step(input bit nf, input bit rr, input bit rw,
                            input bit rdy, input bit dn, input bit er);
    bit apply;
    apply = (nf && (m_ph == 0 || m_ph == 3)) || (m_ph == 2 && dn && (m_defer || nf));
    if (apply) begin
      m_rd_pend = rr; m_wr_pend = rw; m_over = 0; m_err = 0; m_defer = 0;
      m_rd_cnt = 0; m_wr_cnt = 0; m_ph = 0;
    end else if (m_ph == 0 && (m_rd_pend || m_wr_pend) && rdy) begin
      m_cur_wr = m_wr_pend;
      if (m_cur_wr) begin
        m_src = WB + 32'((m_wr_cnt % 2) * LB);
        m_dst = FB + 32'((m_wr_cnt % NL) * LB);
        if (rr && m_rd_pend) m_over = 1;
        m_rd_pend = m_rd_pend | rr;
        m_wr_pend = rw;
      end else begin
        m_src = FB + 32'((m_rd_cnt % NL) * LB);
        m_dst = RB + 32'((m_rd_cnt % 2) * LB);
        if (rw && m_wr_pend) m_over = 1;
        m_wr_pend = m_wr_pend | rw;
        m_rd_pend = rr;
      end
      m_ph = 1;
    end else begin
      if ((rr && m_rd_pend) || (rw && m_wr_pend)) m_over = 1;
      m_rd_pend = m_rd_pend | rr;
      m_wr_pend = m_wr_pend | rw;
      if (m_ph == 1) begin
        m_ph = 2;
        cd_lat = int'($urandom_range(lat_hi, lat_lo));
        if (nf) m_defer = 1;
      end else if (m_ph == 2) begin
        if (nf) m_defer = 1;
        if (dn) begin
          if (er) begin
            m_err = 1; m_ph = 3;
          end else begin
            if (m_cur_wr) m_wr_cnt++;
            else          m_rd_cnt++;
            m_ph = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    check_eq("xfer_start", 32'(xif.xfer_start), 32'(m_ph == 1));
    check_eq("busy",       32'(busy),           32'(m_ph == 1 || m_ph == 2));
    check_eq("xfer_src",   xif.xfer_src,        m_src);
    check_eq("xfer_dst",   xif.xfer_dst,        m_dst);
    check_eq("xfer_len",   32'(xif.xfer_len),   32'(LB));
    check_eq("rd_line",    32'(rd_line),        32'(m_rd_cnt % NL));
    check_eq("wr_line",    32'(wr_line),        32'(m_wr_cnt % NL));
    check_eq("rd_bank",    32'(rd_bank),        32'(m_rd_cnt % 2));
    check_eq("wr_bank",    32'(wr_bank),        32'(m_wr_cnt % 2));
    check_eq("overrun",    32'(overrun),        32'(m_over));
    check_eq("error",      32'(error),          32'(m_err));
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input bit nf, input bit rr, input bit rw, input bit rdy);
    bit dn, er;
    check_all();
    dn = 0; er = 0;
    if (m_ph == 2) begin
      if (cd_lat == 0) begin
        dn = 1;
        er = (int'($urandom_range(99)) < err_pct);
      end else begin
        cd_lat--;
      end
    end
    new_frame = nf; read_new_line = rr; write_new_line = rw;
    xif.xfer_ready = rdy; xif.xfer_done = dn; xif.xfer_err = er;
    model_step(nf, rr, rw, rdy, dn, er);
    @(posedge pclk);
    @(negedge pclk);
  endtask

  initial begin
    reset = 1'b1;
    new_frame = 0; read_new_line = 0; write_new_line = 0;
    xif.xfer_ready = 0; xif.xfer_done = 0; xif.xfer_err = 0;
    lat_lo = 0; lat_hi = 3; err_pct = 0;
    model_reset();
    repeat (2) @(negedge pclk);
    check_all();
    check_eq("rst_len", 32'(xif.xfer_len), 32'd640);
    reset = 1'b0;

    // Single read request.
    step(0, 1, 0, 1);
    repeat (10) step(0, 0, 0, 1);
    check_eq("t1_rd_line", 32'(rd_line), 32'd1);
    check_eq("t1_rd_bank", 32'(rd_bank), 32'd1);

    // Simultaneous read and write: write must go first.
    step(0, 1, 1, 1);
    repeat (20) step(0, 0, 0, 1);
    check_eq("t2_wr_line", 32'(wr_line), 32'd1);
    check_eq("t2_rd_line", 32'(rd_line), 32'd2);

    // Full frame of reads to exercise the line wrap.
    lat_lo = 0; lat_hi = 0;
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < NL; i++) begin
      step(0, 1, 0, 1);
      repeat (4) step(0, 0, 0, 1);
    end
    check_eq("wrap_rd_line", 32'(rd_line), 32'd0);
    check_eq("wrap_rd_bank", 32'(rd_bank), 32'd0);

    // Double request while CDMA not ready: overrun, single transfer.
    lat_hi = 3;
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    check_eq("ovr_flag", 32'(overrun), 32'd1);
    repeat (12) step(0, 0, 0, 1);
    check_eq("ovr_rd_line", 32'(rd_line), 32'd1);

    // Failed transfer halts the scheduler until the next frame.
    err_pct = 100;
    step(0, 1, 1, 1);
    repeat (10) step(0, 0, 0, 1);
    check_eq("err_flag", 32'(error), 32'd1);
    check_eq("err_busy", 32'(busy), 32'd0);
    err_pct = 0;
    step(1, 0, 0, 1);
    check_eq("err_clr", 32'(error), 32'd0);
    check_eq("err_rd_line", 32'(rd_line), 32'd0);
    check_eq("err_wr_line", 32'(wr_line), 32'd0);
    check_eq("err_busy_nf", 32'(busy), 32'd0);

    // new_frame while a transfer is in flight.
    step(0, 1, 0, 1);
    repeat (8) step(0, 0, 0, 1);
    lat_lo = 4; lat_hi = 4;
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    check_eq("nfw_rd_line_hold", 32'(rd_line), 32'd1);
    check_eq("nfw_rd_bank_hold", 32'(rd_bank), 32'd1);
    repeat (6) step(0, 0, 0, 1);
    check_eq("nfw_rd_line_zero", 32'(rd_line), 32'd0);
    check_eq("nfw_rd_bank_zero", 32'(rd_bank), 32'd0);

    // Randomized traffic.
    lat_lo = 0; lat_hi = 4; err_pct = 3;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(49) == 0, $urandom_range(4) == 0,
           $urandom_range(5) == 0, $urandom_range(9) != 0);

    // Asynchronous reset in the middle of a transfer.
    lat_lo = 6; lat_hi = 6; err_pct = 0;
    for (int i = 0; i < 200 && m_ph != 2; i++)
      step(m_ph == 3, 1, 0, 1);
    if (m_ph != 2) begin
      n_chk++; n_fail++;
      $display("FAIL reach_wait: no transfer in flight within budget");
    end
    #2 reset = 1'b1;
    #1;
    check_eq("arst_start",   32'(xif.xfer_start), 32'd0);
    check_eq("arst_busy",    32'(busy),           32'd0);
    check_eq("arst_src",     xif.xfer_src,        32'd0);
    check_eq("arst_dst",     xif.xfer_dst,        32'd0);
    check_eq("arst_len",     32'(xif.xfer_len),   32'd640);
    check_eq("arst_rd_line", 32'(rd_line),        32'd0);
    check_eq("arst_wr_line", 32'(wr_line),        32'd0);
    check_eq("arst_banks",   32'({rd_bank, wr_bank}), 32'd0);
    check_eq("arst_flags",   32'({overrun, error}),   32'd0);
    model_reset();
    new_frame = 0; read_new_line = 0; write_new_line = 0;
    xif.xfer_done = 0; xif.xfer_err = 0;
    @(negedge pclk);
    check_all();
    reset = 1'b0;
    lat_lo = 0; lat_hi = 2;
    step(0, 1, 0, 1);
    repeat (8) step(0, 0, 0, 1);
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dvs_line_xfer_sched.md
# dvs_line_xfer_sched

Line-transfer scheduler for the DVS frame-differencing pipeline. It receives the `read_new_line`, `write_new_line` and `new_frame` pulses from the DVS core and turns them into CDMA transfer commands. A read command fetches the next previous-frame line from DDR into BRAM. A write command stores the freshly computed line from BRAM back to DDR. One CDMA engine is shared between both request types, and BRAM line buffers are ping-ponged so the core never touches a buffer in flight.

## Interface
Parameters:
- `LINE_BYTES`, 640: bytes per line transfer.
- `NUM_LINES`, 480: lines per frame; line index wraps to 0 after `NUM_LINES-1`.
- `FRAME_BASE`, 32'h1000_0000: DDR byte address of line 0 of the stored frame.
- `BRAM_RD_BASE`, 32'hC000_0000: BRAM base of the read ping-pong pair (bank1 = base + `LINE_BYTES`).
- `BRAM_WR_BASE`, 32'hC000_1000: BRAM base of the write ping-pong pair.

Ports:
- `pclk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `new_frame`, in, 1: 1-cycle pulse, start of frame.
- `read_new_line`, in, 1: 1-cycle pulse, request to fetch the next line.
- `write_new_line`, in, 1: 1-cycle pulse, request to store the next line.
- `xfer_ready`, in, 1: CDMA idle and able to accept a command.
- `xfer_done`, in, 1: 1-cycle pulse, current transfer finished.
- `xfer_err`, in, 1: qualified by `xfer_done`; the finished transfer failed.
- `xfer_start`, out, 1: 1-cycle command strobe.
- `xfer_src`, out, 32: source byte address, stable from `xfer_start` until `xfer_done`.
- `xfer_dst`, out, 32: destination byte address, same stability rule as `xfer_src`.
- `xfer_len`, out, 23: byte count; always `LINE_BYTES`.
- `rd_bank`, out, 1: BRAM read bank the core may currently use.
- `wr_bank`, out, 1: BRAM write bank the core may currently fill.
- `rd_line`, out, 10: index of the next line to fetch.
- `wr_line`, out, 10: index of the next line to store.
- `busy`, out, 1: state is ISSUE or WAIT.
- `overrun`, out, 1: sticky flag; a request arrived while the same request type was already pending.
- `error`, out, 1: sticky flag; a CDMA transfer reported an error.

## Operation
- Pending flags:
  - `rd_pend` is set by a `read_new_line` pulse; `wr_pend` is set by a `write_new_line` pulse.
  - A flag is cleared when its command is issued.
  - A pulse arriving while its flag is already set sets `overrun`; the pulse is not queued deeper.
- State machine states: IDLE, ISSUE, WAIT, ERROR.
  - IDLE → ISSUE when (`rd_pend` or `wr_pend`) and `xfer_ready`.
  - Arbitration is fixed priority: write first, then read. Write-back must precede an overwrite of the shared line slot.
  - ISSUE lasts exactly one cycle with `xfer_start`=1, then → WAIT.
  - WAIT → IDLE on `xfer_done` with `xfer_err`=0. On completion:
    - the completed type's line index increments, wrapping at `NUM_LINES`;
    - the completed type's bank toggles;
    - the completed type's DDR offset register adds `LINE_BYTES`, wrapping to 0 together with the index.
  - WAIT → ERROR on `xfer_done` with `xfer_err`=1; `error` is set and no further commands are issued.
  - ERROR → IDLE on `new_frame`.
- Addresses (offset accumulators only, no multiplier):
  - Read: `xfer_src` = `FRAME_BASE` + rd_off; `xfer_dst` = `BRAM_RD_BASE` + `rd_bank`·`LINE_BYTES`.
  - Write: `xfer_src` = `BRAM_WR_BASE` + `wr_bank`·`LINE_BYTES`; `xfer_dst` = `FRAME_BASE` + wr_off.
- `new_frame` handling:
  - Clears both pending flags, `overrun` and `error`.
  - Resets both line indices, offsets and banks to 0.
  - If it arrives in ISSUE or WAIT, it is latched (`frame_defer`) and applied in the cycle of `xfer_done`. In that case it replaces the normal index/bank update and the FSM goes to IDLE even if `xfer_err`=1.
  - A request pulse in the same cycle as an applied `new_frame` is kept: its pending flag is set after the clear.
- A request pulse in the same cycle as issue of the same type sets the flag again (the pulse is counted as new, not as overrun).

## Timing
- Reset values: all outputs 0; `xfer_len` = `LINE_BYTES`. `reset` forces IDLE asynchronously, aborting any transfer. The CDMA is assumed to be reset by the same signal.
- Request sampled at edge k sets its flag at edge k; if IDLE and `xfer_ready`, ISSUE is entered at edge k+1, so `xfer_start` is high for cycle k+1..k+2.
- `xfer_src`/`xfer_dst` are registered at entry to ISSUE.
- Bank, index and `busy` deassertion all update at the edge sampling `xfer_done`.
- Minimum gap between successive `xfer_start` pulses: `xfer_done` cycle + 1 IDLE cycle.
- `xfer_ready`=0 holds the FSM in IDLE with flags retained.

## Test plan
- Reset, then one `read_new_line` pulse with `xfer_ready`=1:
  - `xfer_start` 2 edges later;
  - `xfer_src`=32'h1000_0000, `xfer_dst`=32'hC000_0000, `xfer_len`=640.
  - After `xfer_done`: `rd_line`=1, `rd_bank`=1.
- Read and write pulses in the same cycle:
  - write issues first (src 32'hC000_1000, dst 32'h1000_0000);
  - read issues after the write's `xfer_done` + 1 cycle.
- 480 read transfers:
  - 480th uses src 32'h1000_0000 + 479·640;
  - then `rd_line`=0 and rd_off=0 (wrap).
- Second `read_new_line` pulse while `rd_pend`=1 and `xfer_ready`=0: `overrun`=1; exactly one read issues once `xfer_ready`=1.
- `xfer_done` with `xfer_err`=1:
  - `error`=1 and no further `xfer_start` despite pending requests;
  - after `new_frame`: `error`=0, indices 0, FSM in IDLE.
- `new_frame` during WAIT: indices and banks unchanged until `xfer_done`, then all 0; `reset` asserted mid-WAIT drives all outputs to reset values immediately.
